// File: rtl/sdram_arb_pkg.sv
// Shared types and defaults for the SDRAM command-port arbiter.
package sdram_arb_pkg;

  localparam int unsigned DEF_NUM_REQ = 3;
  localparam int unsigned DEF_ADDR_W  = 23;
  localparam int unsigned DEF_DATA_W  = 32;
  localparam int unsigned DEF_TIMEOUT = 1023;

  localparam int unsigned REQ_RECORD = 0;
  localparam int unsigned REQ_PLAY   = 1;
  localparam int unsigned REQ_CTRL   = 2;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RELEASE
  } arb_state_t;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } arb_op_t;

endpackage

// File: rtl/sdram_arbiter_rr_picker.sv
// Combinational round-robin picker: first pending index after last_grant, wrapping.
module rr_picker #(
  parameter int unsigned NUM_REQ = 3,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] pending,
  input  logic [ID_W-1:0]    last_grant,
  output logic               valid,
  output logic [ID_W-1:0]    winner
);

  always_comb begin : pick
    int unsigned idx;
    logic [ID_W-1:0] sel;
    valid  = 1'b0;
    winner = '0;
    idx    = 0;
    sel    = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = (32'(last_grant) + k) % NUM_REQ;
      sel = ID_W'(idx);
      if (!valid && pending[sel]) begin
        valid  = 1'b1;
        winner = sel;
      end
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Round-robin arbiter sharing one SDRAM command port between the audio cores, with a BUSY watchdog.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [NUM_REQ-1:0]         req_read,
  input  logic [NUM_REQ-1:0]         req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]  req_writedata,
  output logic [DATA_W-1:0]          req_readdata,
  output logic [NUM_REQ-1:0]         req_finished,
  output logic [NUM_REQ-1:0]         req_error,
  output logic                       sdram_read,
  output logic                       sdram_write,
  output logic [ADDR_W-1:0]          sdram_addr,
  output logic [DATA_W-1:0]          sdram_writedata,
  input  logic [DATA_W-1:0]          sdram_readdata,
  input  logic                       sdram_finished,
  output logic [ID_W-1:0]            grant_id,
  output logic                       busy
);

  localparam int unsigned      TMR_W    = $clog2(TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(TIMEOUT);
  localparam logic [ID_W-1:0]  LAST_RST = ID_W'(NUM_REQ - 1);

  arb_state_t        state_q, state_d;
  logic [ID_W-1:0]   last_q, last_d;
  logic [ID_W-1:0]   gid_q, gid_d;
  arb_op_t           op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [TMR_W-1:0]  timer_q, timer_d;

  logic [NUM_REQ-1:0] pending;
  logic               pick_valid;
  logic [ID_W-1:0]    pick_id;
  logic               sel_write;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;
  logic               in_busy;
  logic               timed_out;

  assign pending = req_read | req_write;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_picker (
    .pending    (pending),
    .last_grant (last_q),
    .valid      (pick_valid),
    .winner     (pick_id)
  );

  always_comb begin
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_data  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick_id == ID_W'(i)) begin
        sel_write = req_write[i];
        sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
        sel_data  = req_writedata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      last_q  <= LAST_RST;
      gid_q   <= '0;
      op_q    <= OP_READ;
      addr_q  <= '0;
      data_q  <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gid_q   <= gid_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      timer_q <= timer_d;
    end
  end

  assign in_busy   = (state_q == BUSY);
  assign timed_out = (timer_q == TMR_MAX);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gid_d   = gid_q;
    op_d    = op_q;
    addr_d  = addr_q;
    data_d  = data_q;
    timer_d = timer_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = BUSY;
          last_d  = pick_id;
          gid_d   = pick_id;
          op_d    = sel_write ? OP_WRITE : OP_READ;
          addr_d  = sel_addr;
          data_d  = sel_data;
          timer_d = '0;
        end
      end
      BUSY: begin
        // Finish takes precedence over a coincident timeout.
        if (sdram_finished || timed_out) begin
          state_d = RELEASE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_finished = '0;
    req_error    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gid_q == ID_W'(i)) begin
        req_finished[i] = in_busy && sdram_finished;
        req_error[i]    = in_busy && !sdram_finished && timed_out;
      end
    end
  end

  assign sdram_read      = in_busy && (op_q == OP_READ);
  assign sdram_write     = in_busy && (op_q == OP_WRITE);
  assign sdram_addr      = in_busy ? addr_q : '0;
  assign sdram_writedata = in_busy ? data_q : '0;
  assign req_readdata    = sdram_readdata;
  assign grant_id        = gid_q;
  assign busy            = (state_q != IDLE);

endmodule

// File: tb/tb_sdram_arbiter.sv
// Randomised + directed bench for sdram_arbiter against a transaction-level model.
module tb_sdram_arbiter;

  localparam int NR = 3;
  localparam int AW = 23;
  localparam int DW = 32;
  localparam int TO = 8;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NR-1:0]     req_read;
  logic [NR-1:0]     req_write;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*DW-1:0]  req_writedata;
  logic [DW-1:0]     req_readdata;
  logic [NR-1:0]     req_finished;
  logic [NR-1:0]     req_error;
  logic              sdram_read;
  logic              sdram_write;
  logic [AW-1:0]     sdram_addr;
  logic [DW-1:0]     sdram_writedata;
  logic [DW-1:0]     sdram_readdata;
  logic              sdram_finished;
  logic [IW-1:0]     grant_id;
  logic              busy;

  always #5 clk = ~clk;

  sdram_arbiter #(
    .NUM_REQ (NR),
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .TIMEOUT (TO),
    .ID_W    (IW)
  ) dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .req_read        (req_read),
    .req_write       (req_write),
    .req_addr        (req_addr),
    .req_writedata   (req_writedata),
    .req_readdata    (req_readdata),
    .req_finished    (req_finished),
    .req_error       (req_error),
    .sdram_read      (sdram_read),
    .sdram_write     (sdram_write),
    .sdram_addr      (sdram_addr),
    .sdram_writedata (sdram_writedata),
    .sdram_readdata  (sdram_readdata),
    .sdram_finished  (sdram_finished),
    .grant_id        (grant_id),
    .busy            (busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: phase 0=idle, 1=command outstanding, 2=release gap.
  int          m_phase, m_owner, m_last, m_timer;
  bit          m_wr;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;

  task automatic model_reset();
    m_phase = 0; m_owner = 0; m_last = NR - 1; m_timer = 0;
    m_wr = 1'b0; m_addr = '0; m_data = '0;
  endtask

  initial begin
    logic [NR-1:0] pend, exp_fin, exp_err;
    bit act, found;
    int idx;
    model_reset();
    forever begin
      @(negedge clk);
      #3;
      if (!rst_n) begin
        model_reset();
        check("rst_sdram_read", sdram_read, 0);
        check("rst_sdram_write", sdram_write, 0);
        check("rst_finished", req_finished, 0);
        check("rst_error", req_error, 0);
        check("rst_busy", busy, 0);
        check("rst_grant", grant_id, 0);
      end else begin
        act     = (m_phase == 1);
        exp_fin = (act && sdram_finished) ? NR'(1 << m_owner) : '0;
        exp_err = (act && !sdram_finished && m_timer == TO) ? NR'(1 << m_owner) : '0;
        check("m_sdram_read", sdram_read, act && !m_wr);
        check("m_sdram_write", sdram_write, act && m_wr);
        check("m_sdram_addr", sdram_addr, act ? m_addr : '0);
        check("m_sdram_wdata", sdram_writedata, act ? m_data : '0);
        check("m_finished", req_finished, exp_fin);
        check("m_error", req_error, exp_err);
        check("m_busy", busy, m_phase != 0);
        check("m_grant", grant_id, m_owner);
        check("m_readdata", req_readdata, sdram_readdata);
        case (m_phase)
          0: begin
            pend  = req_read | req_write;
            found = 1'b0;
            for (int k = 1; k <= NR; k++) begin
              idx = (m_last + k) % NR;
              if (!found && pend[idx]) begin
                found   = 1'b1;
                m_owner = idx;
                m_last  = idx;
                m_wr    = req_write[idx];
                m_addr  = req_addr[idx*AW +: AW];
                m_data  = req_writedata[idx*DW +: DW];
                m_timer = 0;
                m_phase = 1;
              end
            end
          end
          1: begin
            if (sdram_finished || m_timer == TO) m_phase = 2;
            else m_timer++;
          end
          default: m_phase = 0;
        endcase
      end
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic clear_all();
    req_read = '0; req_write = '0; sdram_finished = 1'b0;
  endtask

  task automatic set_req(input int i, input bit rd, input bit wr,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_read[i] = rd;
    req_write[i] = wr;
    req_addr[i*AW +: AW] = a;
    req_writedata[i*DW +: DW] = d;
  endtask

  task automatic drain();
    repeat (15) begin step(); clear_all(); end
  endtask

  task automatic do_reset();
    step(); rst_n = 1'b0; clear_all();
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  initial begin
    int cnt, ng;
    int grants[4];
    int exp_order[4];
    logic [NR-1:0] early_err;
    bit quiet;
    exp_order = '{0, 1, 2, 0};
    req_read = '0; req_write = '0; req_addr = '0; req_writedata = '0;
    sdram_readdata = '0; sdram_finished = 1'b0;

    repeat (3) step();
    rst_n = 1'b1;

    // Single read from requester 1
    step(); set_req(1, 1, 0, 23'h000010, '0);
    step(); req_read = '0;
    #3;
    check("single_read_cmd", sdram_read, 1);
    check("single_read_addr", sdram_addr, 23'h000010);
    check("single_read_grant", grant_id, 1);
    repeat (3) step();
    step(); sdram_finished = 1'b1; sdram_readdata = 32'hDEADBEEF;
    #3;
    check("single_read_fin", req_finished, 3'b010);
    check("single_read_data", req_readdata, 32'hDEADBEEF);
    step(); sdram_finished = 1'b0;
    #3;
    check("single_release_busy", busy, 1);
    check("single_release_cmd", sdram_read, 0);
    step();
    #3;
    check("single_idle", busy, 0);

    // Contention from reset: order must be 0,1,2,0
    do_reset();
    step(); req_read = 3'b111;
    cnt = 0; ng = 0;
    for (int t = 0; t < 60 && ng < 4; t++) begin
      step();
      if (sdram_read || sdram_write) begin
        cnt++;
        if (cnt == 1) begin grants[ng] = grant_id; ng++; end
        sdram_finished = (cnt == 2);
      end else begin
        cnt = 0;
        sdram_finished = 1'b0;
      end
    end
    check("contention_count", ng, 4);
    for (int i = 0; i < 4; i++) check("contention_order", grants[i], exp_order[i]);
    drain();

    // Read and write together resolve to write
    step(); set_req(0, 1, 1, 23'h000055, 32'h12345678);
    step(); req_read = '0; req_write = '0;
    #3;
    check("rw_write", sdram_write, 1);
    check("rw_read", sdram_read, 0);
    check("rw_wdata", sdram_writedata, 32'h12345678);
    step(); sdram_finished = 1'b1;
    drain();

    // Timeout with a second requester waiting
    step(); set_req(1, 1, 0, 23'h000100, '0); set_req(2, 1, 0, 23'h000200, '0);
    early_err = '0;
    for (int k = 1; k <= 9; k++) begin
      step(); sdram_finished = 1'b0;
      #3;
      if (k == 1) check("to_grant", grant_id, 1);
      if (k < 9) early_err = early_err | req_error;
      else begin
        check("to_error", req_error, 3'b010);
        check("to_no_fin", req_finished, 0);
      end
    end
    check("to_early_error", early_err, 0);
    step(); req_read = 3'b100;
    #3;
    check("to_release_cmd", sdram_read, 0);
    check("to_release_busy", busy, 1);
    step();
    step();
    #3;
    check("to_next_grant", grant_id, 2);
    check("to_next_cmd", sdram_read, 1);
    drain();

    // Finish coincides with timeout
    step(); set_req(0, 1, 0, 23'h000033, '0);
    for (int k = 1; k <= 9; k++) begin
      step();
      req_read = '0;
      sdram_finished = (k == 9);
      #3;
      if (k == 9) begin
        check("coin_fin", req_finished, 3'b001);
        check("coin_err", req_error, 0);
      end
    end
    drain();

    // Reset in the middle of a transaction
    step(); set_req(1, 1, 0, 23'h000077, '0);
    step(); req_read = '0;
    #3;
    check("rstmid_cmd", sdram_read, 1);
    step(); rst_n = 1'b0; sdram_finished = 1'b1;
    #3;
    check("rstmid_drop", sdram_read, 0);
    check("rstmid_fin", req_finished, 0);
    check("rstmid_err", req_error, 0);
    step(); sdram_finished = 1'b0; req_read = 3'b011;
    step(); rst_n = 1'b1;
    step();
    #3;
    check("rstmid_priority", grant_id, 0);
    check("rstmid_newcmd", sdram_read, 1);
    drain();

    // Random traffic, with quiet stretches that force timeouts
    quiet = 1'b0;
    for (int t = 0; t < 3000; t++) begin
      step();
      if (t % 50 == 0) quiet = ($urandom_range(0, 3) == 0);
      req_read  = NR'($urandom);
      req_write = ($urandom_range(0, 2) == 0) ? NR'($urandom) : '0;
      for (int i = 0; i < NR; i++) begin
        req_addr[i*AW +: AW]      = AW'($urandom);
        req_writedata[i*DW +: DW] = $urandom;
      end
      sdram_readdata = $urandom;
      sdram_finished = !quiet && ($urandom_range(0, 3) == 0);
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
